// File: rtl/life_gen_engine.sv
// Game of Life generation engine: scans one cell per clock into a shadow board, then commits it.
// Define LIFE_WRAP_EN for a toroidal board; the default build treats cells off the board as dead.
module life_gen_engine #(
  parameter int unsigned BIT_WIDTH      = 3,
  parameter int unsigned BIT_HEIGHT     = 3,
  parameter int unsigned FRAMES_PER_GEN = 60
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            frame_tick,
  input  logic                            run,
  input  logic                            step,
  input  logic [BIT_WIDTH+BIT_HEIGHT-1:0] rd_addr,
  output logic                            rd_cell,
  output logic                            busy,
  output logic [15:0]                     gen_count
);

  localparam int unsigned W    = 1 << BIT_WIDTH;
  localparam int unsigned H    = 1 << BIT_HEIGHT;
  localparam int unsigned SIZE = W * H;
  localparam int unsigned AW   = BIT_WIDTH + BIT_HEIGHT;
  localparam int unsigned FcW  = (FRAMES_PER_GEN > 1) ? $clog2(FRAMES_PER_GEN) : 1;

  localparam logic [FcW-1:0]  FcLast  = FcW'(FRAMES_PER_GEN - 1);
  localparam logic [AW-1:0]   IdxLast = AW'(SIZE - 1);
  localparam logic [SIZE-1:0] GliderInit = (SIZE'(1) << 1) | (SIZE'(1) << 10) |
                                           (SIZE'(1) << 16) | (SIZE'(1) << 17) |
                                           (SIZE'(1) << 18);

  typedef enum logic [1:0] {StIdle, StScan, StCommit} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [SIZE-1:0] curr_q, curr_d;
  logic [SIZE-1:0] next_q, next_d;
  logic [15:0]     gen_q, gen_d;
  logic [FcW-1:0]  fc_q, fc_d;
  logic            pending_q, pending_d;

  logic                  start;
  logic                  rollover;
  logic [BIT_HEIGHT-1:0] cur_row, nr;
  logic [BIT_WIDTH-1:0]  cur_col, nc;
  logic                  in_board;
  logic [3:0]            nbr_sum;
  logic                  new_cell;

  assign cur_row = idx_q[AW-1:BIT_WIDTH];
  assign cur_col = idx_q[BIT_WIDTH-1:0];

  // Neighbour coordinates wrap in row/col arithmetic; dead-edge build masks the wrapped ones.
  always_comb begin
    nbr_sum  = '0;
    nr       = '0;
    nc       = '0;
    in_board = 1'b0;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        if (dr != 0 || dc != 0) begin
          nr       = cur_row + BIT_HEIGHT'(dr);
          nc       = cur_col + BIT_WIDTH'(dc);
          in_board = 1'b1;
`ifndef LIFE_WRAP_EN
          if ((dr == -1 && cur_row == '0) || (dr == 1 && cur_row == BIT_HEIGHT'(H - 1))) begin
            in_board = 1'b0;
          end
          if ((dc == -1 && cur_col == '0) || (dc == 1 && cur_col == BIT_WIDTH'(W - 1))) begin
            in_board = 1'b0;
          end
`endif
          if (in_board && curr_q[{nr, nc}]) begin
            nbr_sum = nbr_sum + 4'd1;
          end
        end
      end
    end
  end

  assign new_cell = (nbr_sum == 4'd3) || (curr_q[idx_q] && nbr_sum == 4'd2);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    curr_d  = curr_q;
    next_d  = next_q;
    gen_d   = gen_q;
    start   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pending_q || step) begin
          start   = 1'b1;
          idx_d   = '0;
          state_d = StScan;
        end
      end
      StScan: begin
        next_d[idx_q] = new_cell;
        idx_d         = idx_q + AW'(1);
        if (idx_q == IdxLast) begin
          state_d = StCommit;
        end
      end
      StCommit: begin
        curr_d  = next_q;
        gen_d   = gen_q + 16'd1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // A rollover landing on the same cycle as a start is absorbed into that generation.
  always_comb begin
    fc_d     = fc_q;
    rollover = 1'b0;
    if (frame_tick && run) begin
      if (fc_q == FcLast) begin
        fc_d     = '0;
        rollover = 1'b1;
      end else begin
        fc_d = fc_q + FcW'(1);
      end
    end
    pending_d = start ? 1'b0 : (pending_q || rollover);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      curr_q    <= GliderInit;
      next_q    <= '0;
      gen_q     <= '0;
      fc_q      <= '0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      curr_q    <= curr_d;
      next_q    <= next_d;
      gen_q     <= gen_d;
      fc_q      <= fc_d;
      pending_q <= pending_d;
    end
  end

  assign rd_cell   = curr_q[rd_addr];
  assign busy      = (state_q != StIdle);
  assign gen_count = gen_q;

  // The displayed board and the generation count may only move on the commit edge.
  assert property (@(posedge clk) disable iff (!rst_n)
                   (state_q != StCommit) |=> $stable(curr_q));
  assert property (@(posedge clk) disable iff (!rst_n)
                   (state_q != StCommit) |=> $stable(gen_q));

endmodule

// File: tb/tb_life_gen_engine.sv
// Self-checking bench for life_gen_engine: table vectors, timing sequences and random stepping
// against a cell-by-cell Life model.
module tb_life_gen_engine;

  localparam logic [63:0] GLIDER = 64'h0000_0000_0007_0402;
  localparam logic [63:0] GEN1   = 64'h0000_0000_0206_0500;
  localparam logic [63:0] GEN4   = 64'h0000_0000_0E08_0400;
  localparam logic [63:0] BLOCK  = 64'hC0C0_0000_0000_0000;

  logic        clk;
  logic        rst_n;
  logic        frame_tick;
  logic        run;
  logic        step;
  logic [5:0]  rd_addr;
  logic        rd_cell;
  logic        busy;
  logic [15:0] gen_count;

  int          total;
  int          bad;
  logic [63:0] model_board;
  logic [15:0] model_gen;

  typedef struct {
    int          steps;
    logic [63:0] board;
    logic [15:0] gen;
  } vec_t;

  vec_t vecs[3];

  life_gen_engine #(
    .BIT_WIDTH     (3),
    .BIT_HEIGHT    (3),
    .FRAMES_PER_GEN(60)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .frame_tick(frame_tick),
    .run       (run),
    .step      (step),
    .rd_addr   (rd_addr),
    .rd_cell   (rd_cell),
    .busy      (busy),
    .gen_count (gen_count)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  initial begin
    #20000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Plain cell-by-cell Life rule on an 8x8 board.
  function automatic logic [63:0] life_next(input logic [63:0] b);
    logic [63:0] nb;
    int          n, rr, cc;
    nb = '0;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        n = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if (dr != 0 || dc != 0) begin
              rr = r + dr;
              cc = c + dc;
`ifdef LIFE_WRAP_EN
              rr = (rr + 8) % 8;
              cc = (cc + 8) % 8;
`endif
              if (rr >= 0 && rr < 8 && cc >= 0 && cc < 8) n += int'(b[rr*8+cc]);
            end
          end
        end
        nb[r*8+c] = (n == 3) || (b[r*8+c] && n == 2);
      end
    end
    return nb;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic read_board(output logic [63:0] b);
    b = '0;
    for (int a = 0; a < 64; a++) begin
      rd_addr = 6'(a);
      #1;
      b[a] = rd_cell;
    end
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    while (busy && n < limit) begin
      tick();
      n++;
    end
    check("idle_reached", 64'(busy), 64'd0);
  endtask

  task automatic send_ticks(input int n, output bit saw_busy);
    saw_busy = 1'b0;
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      tick();
      frame_tick = 1'b0;
      if (busy) saw_busy = 1'b1;
      tick();
      if (busy) saw_busy = 1'b1;
    end
  endtask

  task automatic model_advance();
    model_board = life_next(model_board);
    model_gen   = model_gen + 16'd1;
  endtask

  task automatic check_state(input string name);
    logic [63:0] b;
    read_board(b);
    check(name, b, model_board);
    check("gen_count", 64'(gen_count), 64'(model_gen));
  endtask

  // One step pulse from idle; extra_at > 0 fires a second (ignored) step during the scan.
  task automatic gen_step(input int extra_at);
    logic [63:0] pre;
    int          n;
    step = 1'b1;
    tick();
    step = 1'b0;
    check("busy_rise", 64'(busy), 64'd1);
    n   = 0;
    pre = '0;
    while (busy && n < 200) begin
      n++;
      if (n == 65) read_board(pre);
      step = (n == extra_at);
      tick();
    end
    step = 1'b0;
    check("busy_len", 64'(n), 64'd65);
    check("pre_commit_board", pre, model_board);
    model_advance();
    check_state("board");
  endtask

  initial begin
    logic [63:0] b, b40;
    bit          saw;
    total      = 0;
    bad        = 0;
    rst_n      = 1'b0;
    frame_tick = 1'b0;
    run        = 1'b0;
    step       = 1'b0;
    rd_addr    = '0;
    b40        = '0;

    vecs[0] = '{steps: 0, board: GLIDER, gen: 16'd0};
    vecs[1] = '{steps: 1, board: GEN1,   gen: 16'd1};
    vecs[2] = '{steps: 3, board: GEN4,   gen: 16'd4};

    model_board = GLIDER;
    model_gen   = 16'd0;

    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check("reset_busy", 64'(busy), 64'd0);

    for (int i = 0; i < 3; i++) begin
      repeat (vecs[i].steps) gen_step(0);
      read_board(b);
      check("vec_board", b, vecs[i].board);
      check("vec_gen", 64'(gen_count), 64'(vecs[i].gen));
    end

    // Frame pacing: 59 ticks idle, the 60th triggers two cycles later.
    run = 1'b1;
    send_ticks(59, saw);
    check("no_busy_59_ticks", 64'(saw), 64'd0);
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    run        = 1'b0;
    check("busy_1_after_60th", 64'(busy), 64'd0);
    tick();
    check("busy_2_after_60th", 64'(busy), 64'd1);
    wait_idle(200);
    model_advance();
    check_state("paced_board");
    send_ticks(200, saw);
    check("run0_no_busy", 64'(saw), 64'd0);
    check("run0_gen_hold", 64'(gen_count), 64'(model_gen));

    // Collision: step with the rollover tick, plus a step during busy.
    run = 1'b1;
    send_ticks(59, saw);
    frame_tick = 1'b1;
    step       = 1'b1;
    tick();
    frame_tick = 1'b0;
    step       = 1'b0;
    run        = 1'b0;
    check("collision_busy", 64'(busy), 64'd1);
    repeat (5) tick();
    step = 1'b1;
    tick();
    step = 1'b0;
    wait_idle(200);
    model_advance();
    saw = 1'b0;
    repeat (20) begin
      tick();
      if (busy) saw = 1'b1;
    end
    check("collision_single_gen", 64'(saw), 64'd0);
    check_state("collision_board");

    // Rollover while busy is serviced right after the commit.
    run = 1'b1;
    send_ticks(59, saw);
    step = 1'b1;
    tick();
    step       = 1'b0;
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    run        = 1'b0;
    wait_idle(200);
    model_advance();
    check("first_of_two_gen", 64'(gen_count), 64'(model_gen));
    tick();
    check("pending_serviced", 64'(busy), 64'd1);
    wait_idle(200);
    model_advance();
    check_state("second_of_two");

    // Random gaps, ignored frame ticks and dropped steps.
    repeat (20) begin
      repeat ($urandom_range(0, 6)) begin
        frame_tick = 1'($urandom % 2);
        tick();
      end
      frame_tick = 1'b0;
      gen_step(($urandom % 2 == 0) ? int'($urandom_range(1, 60)) : 0);
    end

    // Reset 30 cycles into a scan discards the partial generation.
    step = 1'b1;
    tick();
    step = 1'b0;
    repeat (29) tick();
    rst_n = 1'b0;
    #1;
    check("midscan_busy", 64'(busy), 64'd0);
    read_board(b);
    check("midscan_board", b, GLIDER);
    check("midscan_gen", 64'(gen_count), 64'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    model_board = GLIDER;
    model_gen   = 16'd0;
    saw = 1'b0;
    repeat (70) begin
      tick();
      if (busy) saw = 1'b1;
    end
    check("no_commit_after_reset", 64'(saw), 64'd0);
    check_state("post_reset_board");

    // Long run toward the board edges.
    for (int g = 1; g <= 41; g++) begin
      gen_step(0);
      read_board(b);
`ifdef LIFE_WRAP_EN
      if (g == 32) check("torus_gen32", b, GLIDER);
`else
      if (g == 40) begin
        check("block_gen40", b, BLOCK);
        b40 = b;
      end
      if (g == 41) check("still_gen41", b, b40);
`endif
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
